// File: rtl/divider_top.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and their W forms.
// Define DIV_FAST_SPECIAL_EN to finish divide-by-zero and signed overflow without iterating.
package decode_pkg;
  typedef enum logic [3:0] {
    OP_NOP, OP_ADD, OP_MUL, OP_MULH,
    OP_DIV, OP_DIVU, OP_REM, OP_REMU,
    OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW
  } op_t;
endpackage

module divider_top
  import decode_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid,
  input  op_t             op,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  output logic            done,
  output logic [XLEN-1:0] c
);
  localparam int unsigned CNT_W = 7;
  localparam logic [XLEN-1:0] MIN64 = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN32 = {{(XLEN-31){1'b1}}, {31{1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t            state_q, state_d;
  logic              done_d;
  logic [XLEN-1:0]   c_d;
  logic [XLEN-1:0]   rem_q, rem_d, quo_q, quo_d, div_q, div_d, a_q, a_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_rem_q, is_rem_d, w_q, w_d, neg_q_q, neg_q_d, neg_r_q, neg_r_d;
  logic              dz_q, dz_d, ov_q, ov_d;

  // Op decode
  logic is_div_op, sgn_op, w_op, rem_op;
  always_comb begin
    is_div_op = 1'b1;
    sgn_op    = 1'b0;
    w_op      = 1'b0;
    rem_op    = 1'b0;
    case (op)
      OP_DIV:   sgn_op = 1'b1;
      OP_DIVU:  ;
      OP_REM:   begin sgn_op = 1'b1; rem_op = 1'b1; end
      OP_REMU:  rem_op = 1'b1;
      OP_DIVW:  begin sgn_op = 1'b1; w_op = 1'b1; end
      OP_DIVUW: w_op = 1'b1;
      OP_REMW:  begin sgn_op = 1'b1; w_op = 1'b1; rem_op = 1'b1; end
      OP_REMUW: begin w_op = 1'b1; rem_op = 1'b1; end
      default:  is_div_op = 1'b0;
    endcase
  end

  // Operand prep: W extension, magnitudes and special-case detection
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag;
  logic            sa, sb, dz_in, ov_in;
  always_comb begin
    if (w_op) begin
      a_ext = sgn_op ? {{(XLEN-32){a_in[31]}}, a_in[31:0]} : {{(XLEN-32){1'b0}}, a_in[31:0]};
      b_ext = sgn_op ? {{(XLEN-32){b_in[31]}}, b_in[31:0]} : {{(XLEN-32){1'b0}}, b_in[31:0]};
    end else begin
      a_ext = a_in;
      b_ext = b_in;
    end
    sa    = sgn_op & a_ext[XLEN-1];
    sb    = sgn_op & b_ext[XLEN-1];
    a_mag = sa ? XLEN'(-a_ext) : a_ext;
    b_mag = sb ? XLEN'(-b_ext) : b_ext;
    dz_in = (b_ext == '0);
    ov_in = sgn_op & (b_ext == '1) & (a_ext == (w_op ? MIN32 : MIN64));
  end

  // One restoring step; the shifted remainder needs one extra bit for unsigned divisors
  logic [XLEN:0]   rem_sh;
  logic            ge;
  logic [XLEN-1:0] rem_step, quo_step;
  always_comb begin
    rem_sh   = {rem_q, quo_q[XLEN-1]};
    ge       = (rem_sh >= {1'b0, div_q});
    rem_step = ge ? XLEN'(rem_sh - {1'b0, div_q}) : rem_sh[XLEN-1:0];
    quo_step = {quo_q[XLEN-2:0], ge};
  end

  function automatic logic [XLEN-1:0] fix_result(
    input logic [XLEN-1:0] q, input logic [XLEN-1:0] r, input logic [XLEN-1:0] a,
    input logic is_rem, input logic w, input logic neg_q, input logic neg_r,
    input logic dz, input logic ov);
    logic [XLEN-1:0] res;
    if (dz)          res = is_rem ? a : '1;
    else if (ov)     res = is_rem ? '0 : (w ? MIN32 : MIN64);
    else if (is_rem) res = neg_r ? XLEN'(-r) : r;
    else             res = neg_q ? XLEN'(-q) : q;
    if (w) res = {{(XLEN-32){res[31]}}, res[31:0]};
    return res;
  endfunction

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    c_d      = c;
    rem_d    = rem_q;
    quo_d    = quo_q;
    div_d    = div_q;
    a_d      = a_q;
    cnt_d    = cnt_q;
    is_rem_d = is_rem_q;
    w_d      = w_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    dz_d     = dz_q;
    ov_d     = ov_q;
    case (state_q)
      IDLE: begin
        if (valid && is_div_op) begin
          a_d      = a_ext;
          div_d    = b_mag;
          rem_d    = '0;
          quo_d    = w_op ? {a_mag[31:0], {(XLEN-32){1'b0}}} : a_mag;
          cnt_d    = w_op ? CNT_W'(32) : CNT_W'(64);
          is_rem_d = rem_op;
          w_d      = w_op;
          neg_q_d  = sa ^ sb;
          neg_r_d  = sa;
          dz_d     = dz_in;
          ov_d     = ov_in;
          state_d  = CALC;
`ifdef DIV_FAST_SPECIAL_EN
          if (dz_in || ov_in) begin
            state_d = FIN;
            done_d  = 1'b1;
            c_d     = fix_result('0, '0, a_ext, rem_op, w_op, sa ^ sb, sa, dz_in, ov_in);
          end
`endif
        end
      end
      CALC: begin
        if (!valid) begin
          state_d = IDLE;
        end else begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = FIN;
            done_d  = 1'b1;
            c_d     = fix_result(quo_step, rem_step, a_q, is_rem_q, w_q, neg_q_q, neg_r_q,
                                 dz_q, ov_q);
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      done     <= 1'b0;
      c        <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      a_q      <= '0;
      cnt_q    <= '0;
      is_rem_q <= 1'b0;
      w_q      <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dz_q     <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      done     <= done_d;
      c        <= c_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      div_q    <= div_d;
      a_q      <= a_d;
      cnt_q    <= cnt_d;
      is_rem_q <= is_rem_d;
      w_q      <= w_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      dz_q     <= dz_d;
      ov_q     <= ov_d;
    end
  end
endmodule

// File: tb/tb_divider_top.sv
// Scoreboard bench for divider_top: the driver queues expected result and done cycle,
// a monitor checks each done pulse against the queue head.
module tb_divider_top;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  op_t         op;
  logic [63:0] a_in, b_in;
  logic        done;
  logic [63:0] c;

`ifdef DIV_FAST_SPECIAL_EN
  localparam int SPEC64 = 1;
  localparam int SPEC32 = 1;
`else
  localparam int SPEC64 = 65;
  localparam int SPEC32 = 33;
`endif

  divider_top dut (
    .clk   (clk),
    .reset (reset),
    .valid (valid),
    .op    (op),
    .a_in  (a_in),
    .b_in  (b_in),
    .done  (done),
    .c     (c)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int done_count = 0;

  logic [63:0] exp_c_q[$];
  int          exp_cyc_q[$];
  string       exp_name_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation
  string       mon_name;
  logic [63:0] mon_c;
  int          mon_cyc;
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) begin
      done_count++;
      if (exp_c_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, expected no pulse", cyc);
      end else begin
        mon_c    = exp_c_q.pop_front();
        mon_cyc  = exp_cyc_q.pop_front();
        mon_name = exp_name_q.pop_front();
        check({mon_name, "_c"}, c, mon_c);
        check({mon_name, "_done_cycle"}, 64'(cyc), 64'(mon_cyc));
      end
    end
  end

  task automatic run_op(input op_t o, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_c, input int lat, input string name,
                        input bit keep, input bit churn);
    int d;
    bit seen;
    @(negedge clk);
    op = o; a_in = a; b_in = b; valid = 1'b1;
    d = cyc;
    exp_c_q.push_back(exp_c);
    exp_cyc_q.push_back(d + lat);
    exp_name_q.push_back(name);
    seen = 1'b0;
    for (int i = 0; i < lat + 8 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
      else if (churn) begin
        a_in = {$urandom, $urandom};
        b_in = {$urandom, $urandom};
      end
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL %s_timeout: no done within %0d cycles, expected done at cycle %0d",
               name, lat + 8, d + lat);
      exp_c_q.delete();
      exp_cyc_q.delete();
      exp_name_q.delete();
    end
    if (!keep) valid = 1'b0;
  endtask

  // Start an op and kill it by dropping valid or by reset; no done may follow
  task automatic run_abort(input op_t o, input logic [63:0] a, input logic [63:0] b,
                           input int drop_after, input bit use_reset, input string name);
    int dc;
    @(negedge clk);
    op = o; a_in = a; b_in = b; valid = 1'b1;
    dc = done_count;
    repeat (drop_after) @(negedge clk);
    valid = 1'b0;
    if (use_reset) begin
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check({name, "_reset_done"}, 64'(done), 64'd0);
      check({name, "_reset_c"}, c, 64'd0);
    end
    repeat (80) @(negedge clk);
    check({name, "_no_done"}, 64'(done_count), 64'(dc));
  endtask

  initial begin
    int dc;
    reset = 1'b1; valid = 1'b0; op = OP_NOP; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_done", 64'(done), 64'd0);
    check("reset_c", c, 64'd0);

    // Non-divide op with valid is ignored
    dc = done_count;
    @(negedge clk);
    op = OP_MUL; a_in = 64'd9; b_in = 64'd3; valid = 1'b1;
    repeat (5) @(negedge clk);
    valid = 1'b0;
    repeat (70) @(negedge clk);
    check("nondiv_no_done", 64'(done_count), 64'(dc));

    run_op(OP_DIV,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2,  64'hFFFF_FFFF_FFFF_FFFD, 65, "div_m7_2",  0, 0);
    run_op(OP_REM,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2,  64'hFFFF_FFFF_FFFF_FFFF, 65, "rem_m7_2",  0, 0);
    run_op(OP_DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 65, "divu_big",  0, 0);
    run_op(OP_REMU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'hF,                   65, "remu_big",  0, 0);
    run_op(OP_DIVW,  64'h1_8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, SPEC32, "divw_ovf", 0, 0);
    run_op(OP_REMW,  64'h1_8000_0000, 64'hFFFF_FFFF, 64'h0,                   SPEC32, "remw_ovf", 0, 0);
    run_op(OP_DIV,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, SPEC64, "div_ovf", 0, 0);
    run_op(OP_REM,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, SPEC64, "rem_ovf", 0, 0);
    run_op(OP_DIV,   64'h1234, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, SPEC64, "div_by0",   0, 0);
    run_op(OP_REMU,  64'h1234, 64'h0, 64'h1234,                SPEC64, "remu_by0",  0, 0);
    run_op(OP_DIVUW, 64'h5,    64'h0, 64'hFFFF_FFFF_FFFF_FFFF, SPEC32, "divuw_by0", 0, 0);
    run_op(OP_REMW,  64'hDEAD_0000_8000_0005, 64'h0, 64'hFFFF_FFFF_8000_0005, SPEC32, "remw_by0", 0, 0);
    run_op(OP_DIVW,  64'h1234_5678_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 33, "divw_m100_7", 0, 0);
    run_op(OP_REMW,  64'h1234_5678_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 33, "remw_m100_7", 0, 0);
    run_op(OP_DIVUW, 64'hFFFF_FFF0, 64'd1, 64'hFFFF_FFFF_FFFF_FFF0, 33, "divuw_sext", 0, 0);
    run_op(OP_REMUW, 64'h8000_0005, 64'h10, 64'h5, 33, "remuw_small", 0, 0);

    run_abort(OP_DIV, 64'd1000, 64'd3, 10, 0, "abort_valid");
    run_op(OP_DIVU, 64'd100, 64'd7, 64'd14, 65, "divu_restart", 0, 0);
    run_abort(OP_DIV, 64'd1000, 64'd3, 20, 1, "abort_reset");

    // Operand churn during the op, then a back-to-back op the cycle after done
    run_op(OP_DIVUW, 64'hFFFF_FFFF, 64'd3, 64'h0000_0000_5555_5555, 33, "divuw_churn", 1, 1);
    run_op(OP_REMU,  64'd100, 64'd7, 64'd2, 65, "remu_b2b", 0, 0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(exp_c_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
